// File: rtl/mips_pkg.sv
// mips_pkg: shared width, MEM-stage FSM state type and timeout default for the MIPS pipeline.
package mips_pkg;
    localparam int S               = 32;
    localparam int TIMEOUT_DEFAULT = 15;
    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
endpackage

// File: rtl/dmem_timeout_cnt.sv
// dmem_timeout_cnt: counts cycles while en is high and flags the TIMEOUT-th cycle.
// Ports: clk, reset (sync, active-high), en (count while high, clear when low),
//        tc (high during the TIMEOUT-th consecutive enabled cycle).
module dmem_timeout_cnt #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tc
);
    localparam int W = $clog2(TIMEOUT + 1);
    logic [W-1:0] cnt_q;
    always_ff @(posedge clk) begin
        if (reset || !en) cnt_q <= '0;
        else              cnt_q <= cnt_q + W'(1);
    end
    assign tc = en && (cnt_q == W'(TIMEOUT - 1));
endmodule

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: sequences MEM-stage loads/stores against a req/ack data memory.
// Ports: clk, reset (sync, active-high); EX/MEM side mem_valid/mem_read/mem_write/
//        mem_addr/mem_wdata; memory side dm_req/dm_we/dm_addr/dm_wdata (registered
//        outputs) and dm_ack/dm_rdata; pipeline side stall, wb_en, wb_bubble,
//        mem_ReadData (registered) and sticky err.
// Build option: DMEM_TIMEOUT_EN aborts a request after TIMEOUT REQ cycles and squashes it.
module dmem_access_ctrl #(
    parameter int S       = mips_pkg::S,
    parameter int TIMEOUT = mips_pkg::TIMEOUT_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         mem_valid,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [S-1:0] mem_addr,
    input  logic [S-1:0] mem_wdata,
    output logic         dm_req,
    output logic         dm_we,
    output logic [S-1:0] dm_addr,
    output logic [S-1:0] dm_wdata,
    input  logic         dm_ack,
    input  logic [S-1:0] dm_rdata,
    output logic         stall,
    output logic         wb_en,
    output logic         wb_bubble,
    output logic [S-1:0] mem_ReadData,
    output logic         err
);
    import mips_pkg::*;

    state_t       state_q, state_d;
    logic         req_q, req_d, we_q, we_d, err_q, err_d, to_q, to_d, timeout;
    logic [S-1:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;

`ifdef DMEM_TIMEOUT_EN
    dmem_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (state_q == REQ),
        .tc    (timeout)
    );
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
    assign timeout        = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        to_d      = to_q;
        stall     = 1'b0;
        wb_en     = 1'b1;
        wb_bubble = 1'b1;
        case (state_q)
            IDLE: begin
                if (mem_valid && (mem_read || mem_write)) begin
                    stall   = 1'b1;
                    wb_en   = 1'b0;
                    req_d   = 1'b1;
                    we_d    = mem_write;
                    addr_d  = mem_addr;
                    wdata_d = mem_wdata;
                    state_d = REQ;
                end else begin
                    wb_bubble = !mem_valid;
                end
            end
            REQ: begin
                stall = 1'b1;
                wb_en = 1'b0;
                if (dm_ack) begin
                    req_d   = 1'b0;
                    rdata_d = we_q ? '0 : dm_rdata;
                    state_d = RESP;
                end else if (timeout) begin
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    to_d    = 1'b1;
                    rdata_d = '0;
                    state_d = RESP;
                end
            end
            RESP: begin
                wb_bubble = to_q;
                to_d      = 1'b0;
                // Clearing here keeps mem_ReadData at 0 for ALU ops that follow in IDLE.
                rdata_d   = '0;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (reset) begin
            stall     = 1'b0;
            wb_en     = 1'b1;
            wb_bubble = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            to_q    <= to_d;
        end
    end

    assign dm_req       = req_q;
    assign dm_we        = we_q;
    assign dm_addr      = addr_q;
    assign dm_wdata     = wdata_q;
    assign mem_ReadData = rdata_q;
    assign err          = err_q;
endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb_dmem_access_ctrl: scoreboard bench for dmem_access_ctrl.
module tb_dmem_access_ctrl;
    logic        clk = 1'b0, reset = 1'b1;
    logic        mem_valid = 1'b0, mem_read = 1'b0, mem_write = 1'b0;
    logic [31:0] mem_addr = '0, mem_wdata = '0;
    logic        dm_req, dm_we, dm_ack = 1'b0;
    logic [31:0] dm_addr, dm_wdata, dm_rdata = '0, mem_ReadData;
    logic        stall, wb_en, wb_bubble, err;
    int          checks = 0, failures = 0, wb_seen = 0, n_exp = 0;
    logic [31:0] exp_q[$];

    dmem_access_ctrl dut (
        .clk(clk), .reset(reset), .mem_valid(mem_valid), .mem_read(mem_read),
        .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_ack(dm_ack), .dm_rdata(dm_rdata), .stall(stall), .wb_en(wb_en),
        .wb_bubble(wb_bubble), .mem_ReadData(mem_ReadData), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && wb_en && !wb_bubble) begin
            wb_seen++;
            if (exp_q.size() == 0) check("sb_extra_wb", 32'd1, 32'd0);
            else                   check("sb_rdata", mem_ReadData, exp_q.pop_front());
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic alu_op;
        mem_valid = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
        exp_q.push_back(32'd0);
        n_exp++;
        @(negedge clk);
        check("alu_stall", stall, 0);
        check("alu_wben", wb_en, 1);
        check("alu_bubble", wb_bubble, 0);
        check("alu_req", dm_req, 0);
        step();
        mem_valid = 1'b0;
    endtask

    task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input int dly, input logic [31:0] rdata);
        int st = 0;
        mem_valid = 1'b1; mem_read = rd; mem_write = wr;
        mem_addr = addr; mem_wdata = wdata; dm_ack = 1'b0;
        exp_q.push_back(wr ? 32'd0 : rdata);
        n_exp++;
        @(negedge clk);
        st += int'(stall);
        check("idle_wben", wb_en, 0);
        step();
        for (int k = 1; k <= dly; k++) begin
            dm_ack   = (k == dly);
            dm_rdata = (k == dly) ? rdata : $urandom;
            @(negedge clk);
            st += int'(stall);
            check("req_req", dm_req, 1);
            check("req_we", dm_we, wr);
            check("req_addr", dm_addr, addr);
            check("req_wdata", dm_wdata, wdata);
            step();
        end
        dm_ack = 1'b0;
        @(negedge clk);
        st += int'(stall);
        check("resp_wben", wb_en, 1);
        check("resp_req", dm_req, 0);
        check("stall_cycles", st, dly + 1);
        step();
        mem_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    endtask

    initial begin
        step();
        @(negedge clk);
        check("rst_req", dm_req, 0);
        check("rst_rdata", mem_ReadData, 0);
        check("rst_err", err, 0);
        check("rst_bubble", wb_bubble, 1);
        check("rst_wben", wb_en, 1);
        check("rst_stall", stall, 0);
        step();
        reset = 1'b0;
        @(negedge clk);
        check("idle_bubble", wb_bubble, 1);

        step();
        alu_op();
        access(1'b1, 1'b0, 32'h0000_0010, 32'h0, 1, 32'hDEAD_BEEF);
        @(negedge clk);
        check("after_load_rdata", mem_ReadData, 0);
        step();
        access(1'b0, 1'b1, 32'h0000_0020, 32'h1234_5678, 4, 32'h0);
        access(1'b1, 1'b0, 32'h0000_0100, 32'h0, 1, 32'hCAFE_0001);
        access(1'b1, 1'b0, 32'h0000_0104, 32'h0, 1, 32'hCAFE_0002);
        access(1'b1, 1'b1, 32'h0000_0200, 32'hA5A5_5A5A, 2, 32'hFFFF_FFFF);
        alu_op();

        mem_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; mem_addr = 32'h40;
        step();
        @(negedge clk);
        check("rreq_req", dm_req, 1);
        step();
        reset = 1'b1;
        @(negedge clk);
        check("rreq_bubble", wb_bubble, 1);
        check("rreq_stall", stall, 0);
        check("rreq_wben", wb_en, 1);
        step();
        @(negedge clk);
        check("rreq_req_drop", dm_req, 0);
        step();
        reset = 1'b0; mem_valid = 1'b0; mem_read = 1'b0;
        dm_ack = 1'b1; dm_rdata = 32'h1111_2222;
        @(negedge clk);
        check("post_rst_req", dm_req, 0);
        check("post_rst_rdata", mem_ReadData, 0);
        check("post_rst_err", err, 0);
        check("post_rst_stall", stall, 0);
        step();
        dm_ack = 1'b0;
        @(negedge clk);
        check("late_ack_req", dm_req, 0);
        check("late_ack_rdata", mem_ReadData, 0);
        step();
        access(1'b1, 1'b0, 32'h0000_0300, 32'h0, 3, 32'h0BAD_F00D);

`ifdef DMEM_TIMEOUT_EN
        mem_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; mem_addr = 32'h80;
        step();
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            check("to_req", dm_req, 1);
            step();
        end
        @(negedge clk);
        check("to_req_drop", dm_req, 0);
        check("to_err", err, 1);
        check("to_bubble", wb_bubble, 1);
        check("to_rdata", mem_ReadData, 0);
        step();
        mem_valid = 1'b0; mem_read = 1'b0;
        access(1'b1, 1'b0, 32'h0000_0084, 32'h0, 1, 32'h7777_8888);
        check("to_err_sticky", err, 1);
`else
        check("err_tied", err, 0);
`endif

        step();
        check("sb_left", exp_q.size(), 0);
        check("wb_count", wb_seen, n_exp);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
